dap_sram_resp: RTL and testbench

//  Responder for the avr_dap request interface: services addr/d_wr/w_rq/r_rq and returns rq_ack/d_rd.

---
 rtl/dap_sram_resp.sv | 200 ++++++++++++++++++++
 tb/tb_dap_sram_resp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dap_sram_resp.sv
// dap_sram_resp: DAP word-request and video-read responder for a 256Kx16 async SRAM.
// Rev 1.0
`default_nettype none

module dap_sram_resp #(
   parameter int ACC_CYC = 2,
   parameter int WE_CYC  = 2,
   parameter int VID_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] addr,
   input  logic [15:0] d_wr,
   input  logic        w_rq,
   input  logic        r_rq,
   output logic        rq_ack,
   output logic [15:0] d_rd,
   input  logic        vid_rq,
   input  logic [17:0] vid_addr,
   output logic        vid_ack,
   output logic [15:0] vid_data,
   inout  wire  [15:0] sram_dq,
   output logic [17:0] sram_addr,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam int CW = $clog2(((ACC_CYC > WE_CYC) ? ACC_CYC : WE_CYC) + 1);
   localparam int VW = $clog2(VID_MAX + 1);
   localparam logic [CW-1:0] ACC_LAST = CW'(ACC_CYC);
   localparam logic [CW-1:0] WE_LAST  = CW'(WE_CYC);
   localparam logic [VW-1:0] VID_LIM  = VW'(VID_MAX);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_V = 3'd1,
      S_RD_A = 3'd2,
      S_WR   = 3'd3,
      S_TURN = 3'd4,
      S_RNG  = 3'd5
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [VW-1:0] vid_cnt, vid_cnt_nx;
   logic          rearm, rearm_nx;
   logic          prev_rd, prev_rd_nx;
   logic          rng_rd, rng_rd_nx;
   logic [17:0]   addr_nx;
   logic [15:0]   wr_data, wr_data_nx;
   logic          dq_oe, dq_oe_nx;
   logic          ce_nx, oe_nx, we_nx, bl_nx, bl_n;
   logic          rq_ack_nx, vid_ack_nx;
   logic [15:0]   d_rd_nx, vid_data_nx;

   logic dap_pend, vid_win, addr_ok;

   assign dap_pend = (w_rq | r_rq) & ~rearm;
   assign vid_win  = vid_rq & ~(dap_pend & (vid_cnt == VID_LIM));
   assign addr_ok  = (addr[23:18] == 6'd0);

   assign sram_dq   = dq_oe ? wr_data : 16'hzzzz;
   assign sram_ub_n = bl_n;
   assign sram_lb_n = bl_n;

   // Strobes are registered from the current state, so each access starts with
   // one setup cycle where sram_addr is already stable and all strobes are high.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      vid_cnt_nx  = vid_cnt;
      rearm_nx    = 1'b0;
      prev_rd_nx  = prev_rd;
      rng_rd_nx   = rng_rd;
      addr_nx     = sram_addr;
      wr_data_nx  = wr_data;
      dq_oe_nx    = 1'b0;
      ce_nx       = 1'b1;
      oe_nx       = 1'b1;
      we_nx       = 1'b1;
      bl_nx       = 1'b1;
      rq_ack_nx   = 1'b0;
      vid_ack_nx  = 1'b0;
      d_rd_nx     = d_rd;
      vid_data_nx = vid_data;
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            if (vid_win) begin
               state_nx = S_RD_V;
               addr_nx  = vid_addr;
               if (dap_pend) vid_cnt_nx = vid_cnt + 1'b1;
            end else if (dap_pend) begin
               vid_cnt_nx = '0;
               prev_rd_nx = 1'b0;
               rng_rd_nx  = ~w_rq;
               if (!addr_ok) begin
                  state_nx = S_RNG;
               end else if (w_rq) begin
                  addr_nx    = addr[17:0];
                  wr_data_nx = d_wr;
                  state_nx   = prev_rd ? S_TURN : S_WR;
               end else begin
                  addr_nx  = addr[17:0];
                  state_nx = S_RD_A;
               end
            end
         end
         S_RD_V, S_RD_A: begin
            if (cnt == ACC_LAST) begin
               state_nx   = S_IDLE;
               prev_rd_nx = 1'b1;
               if (state == S_RD_V) begin
                  vid_ack_nx  = 1'b1;
                  vid_data_nx = sram_dq;
               end else begin
                  rq_ack_nx = 1'b1;
                  rearm_nx  = 1'b1;
                  d_rd_nx   = sram_dq;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
               ce_nx  = 1'b0;
               oe_nx  = 1'b0;
               bl_nx  = 1'b0;
            end
         end
         S_WR: begin
            ce_nx    = 1'b0;
            bl_nx    = 1'b0;
            dq_oe_nx = 1'b1;
            if (cnt == WE_LAST) begin
               rq_ack_nx = 1'b1;
               rearm_nx  = 1'b1;
               state_nx  = S_IDLE;
            end else begin
               we_nx  = 1'b0;
               cnt_nx = cnt + 1'b1;
            end
         end
         S_TURN: begin
            state_nx = S_WR;
            cnt_nx   = '0;
         end
         S_RNG: begin
            rq_ack_nx = 1'b1;
            rearm_nx  = 1'b1;
            state_nx  = S_IDLE;
            if (rng_rd) d_rd_nx = 16'hFFFF;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         vid_cnt   <= '0;
         rearm     <= 1'b0;
         prev_rd   <= 1'b0;
         rng_rd    <= 1'b0;
         sram_addr <= '0;
         wr_data   <= '0;
         dq_oe     <= 1'b0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         bl_n      <= 1'b1;
         rq_ack    <= 1'b0;
         vid_ack   <= 1'b0;
         d_rd      <= '0;
         vid_data  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         vid_cnt   <= vid_cnt_nx;
         rearm     <= rearm_nx;
         prev_rd   <= prev_rd_nx;
         rng_rd    <= rng_rd_nx;
         sram_addr <= addr_nx;
         wr_data   <= wr_data_nx;
         dq_oe     <= dq_oe_nx;
         sram_ce_n <= ce_nx;
         sram_oe_n <= oe_nx;
         sram_we_n <= we_nx;
         bl_n      <= bl_nx;
         rq_ack    <= rq_ack_nx;
         vid_ack   <= vid_ack_nx;
         d_rd      <= d_rd_nx;
         vid_data  <= vid_data_nx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dap_sram_resp.sv
// tb_dap_sram_resp: directed vector bench for dap_sram_resp with a behavioural async SRAM.
`default_nettype none

module tb_dap_sram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] addr;
   logic [15:0] d_wr;
   logic        w_rq, r_rq;
   logic        rq_ack;
   logic [15:0] d_rd;
   logic        vid_rq;
   logic [17:0] vid_addr;
   logic        vid_ack;
   logic [15:0] vid_data;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   int checks = 0;
   int errors = 0;
   int ack_tot = 0, vid_tot = 0, ce_tot = 0, we_tot = 0;

   logic [15:0] mem [0:262143];

   always #5 clk = ~clk;

   dap_sram_resp #(.ACC_CYC(2), .WE_CYC(2), .VID_MAX(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .d_wr(d_wr), .w_rq(w_rq), .r_rq(r_rq),
      .rq_ack(rq_ack), .d_rd(d_rd), .vid_rq(vid_rq), .vid_addr(vid_addr),
      .vid_ack(vid_ack), .vid_data(vid_data), .sram_dq(sram_dq),
      .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   // Async SRAM: drives on ce/oe low, latches on the rising edge of we_n.
   assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
   always @(posedge sram_we_n) if (!sram_ce_n) mem[sram_addr] = sram_dq;

   always @(negedge clk) begin
      ack_tot = ack_tot + int'(rq_ack);
      vid_tot = vid_tot + int'(vid_ack);
      ce_tot  = ce_tot + int'(!sram_ce_n);
      we_tot  = we_tot + int'(!sram_we_n);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic rd, input logic [23:0] a, input logic [15:0] d,
                       output int lat, output int acks, output int ce, output int we);
      int a0, c0, w0;
      logic got;
      @(negedge clk);
      a0 = ack_tot; c0 = ce_tot; w0 = we_tot;
      addr = a; d_wr = d; w_rq = wr; r_rq = rd;
      lat = 0; got = 1'b0;
      while (!got && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (rq_ack) got = 1'b1;
      end
      w_rq = 1'b0; r_rq = 1'b0;
      repeat (3) @(negedge clk);
      acks = ack_tot - a0; ce = ce_tot - c0; we = we_tot - w0;
      if (!got) lat = -1;
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [23:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      int          lat;
      int          ce;
      int          we;
   } vec_t;

   vec_t vt [9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, acks, ce, we, a0, n, vack_i, drive_i, ack_i;
      logic got;

      // lat counts edges from the first edge that sees the request up to the ack edge
      vt[0] = '{1'b1, 1'b0, 24'h000123, 16'hBEEF, 16'h0000, 4, 3, 2};
      vt[1] = '{1'b0, 1'b1, 24'h000123, 16'h0000, 16'hBEEF, 4, 2, 0};
      vt[2] = '{1'b1, 1'b0, 24'h03FFFF, 16'h1234, 16'hBEEF, 5, 3, 2};
      vt[3] = '{1'b1, 1'b0, 24'h000000, 16'hA5A5, 16'hBEEF, 4, 3, 2};
      vt[4] = '{1'b0, 1'b1, 24'h03FFFF, 16'h0000, 16'h1234, 4, 2, 0};
      vt[5] = '{1'b0, 1'b1, 24'h000000, 16'h0000, 16'hA5A5, 4, 2, 0};
      vt[6] = '{1'b0, 1'b1, 24'h400000, 16'h0000, 16'hFFFF, 2, 0, 0};
      vt[7] = '{1'b1, 1'b0, 24'h040000, 16'hDEAD, 16'hFFFF, 2, 0, 0};
      vt[8] = '{1'b0, 1'b1, 24'h000000, 16'h0000, 16'hA5A5, 4, 2, 0};

      mem[18'h00100] = 16'h7777;
      mem[18'h000AA] = 16'hCAFE;
      rst = 1'b1; addr = '0; d_wr = '0; w_rq = 1'b0; r_rq = 1'b0;
      vid_rq = 1'b0; vid_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rq_ack", rq_ack, 0);
      chk("rst_vid_ack", vid_ack, 0);
      chk("rst_d_rd", d_rd, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
      chk("rst_dq_z", (sram_dq === 16'hzzzz), 1);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         xfer(vt[i].wr, vt[i].rd, vt[i].a, vt[i].d, lat, acks, ce, we);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_acks", i), acks, 1);
         chk($sformatf("v%0d_ce_cycles", i), ce, vt[i].ce);
         chk($sformatf("v%0d_we_cycles", i), we, vt[i].we);
         chk($sformatf("v%0d_d_rd", i), d_rd, vt[i].exp_rd);
      end

      // Simultaneous write and read: only the write happens
      xfer(1'b1, 1'b1, 24'h000200, 16'h5A5A, lat, acks, ce, we);
      chk("both_acks", acks, 1);
      chk("both_we_cycles", we, 2);
      chk("both_d_rd_kept", d_rd, 16'hA5A5);
      xfer(1'b0, 1'b1, 24'h000200, 16'h0000, lat, acks, ce, we);
      chk("both_readback", d_rd, 16'h5A5A);
      chk("both_readback_lat", lat, 4);

      // Video read then DAP write: turnaround before the bus is driven
      @(negedge clk);
      vid_addr = 18'h00100; vid_rq = 1'b1;
      addr = 24'h000300; d_wr = 16'h0F0F; w_rq = 1'b1;
      vack_i = -1; drive_i = -1; ack_i = -1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (k == 0) vid_rq = 1'b0;
         if (vid_ack && vack_i < 0) vack_i = k;
         if (sram_oe_n && sram_dq !== 16'hzzzz && drive_i < 0) drive_i = k;
         if (rq_ack && ack_i < 0) begin
            ack_i = k;
            w_rq = 1'b0;
         end
      end
      w_rq = 1'b0;
      chk("turn_vid_ack_at", vack_i, 3);
      chk("turn_drive_gap", drive_i - vack_i, 3);
      chk("turn_wr_ack_gap", ack_i - vack_i, 5);
      chk("turn_vid_data", vid_data, 16'h7777);
      chk("turn_mem", mem[18'h00300], 16'h0F0F);

      // Reset during the we_n-low phase of a write
      @(negedge clk);
      addr = 24'h000500; d_wr = 16'h1111; w_rq = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("rstwr_we_low", sram_we_n, 0);
      @(negedge clk);
      a0 = ack_tot;
      rst = 1'b1; w_rq = 1'b0;
      @(posedge clk); #1;
      chk("rstwr_we_n", sram_we_n, 1);
      chk("rstwr_dq_z", (sram_dq === 16'hzzzz), 1);
      chk("rstwr_no_ack", rq_ack, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstwr_ack_count", ack_tot - a0, 0);
      xfer(1'b1, 1'b0, 24'h000500, 16'h2222, lat, acks, ce, we);
      chk("rstwr_fresh_lat", lat, 4);
      chk("rstwr_fresh_acks", acks, 1);
      xfer(1'b0, 1'b1, 24'h000500, 16'h0000, lat, acks, ce, we);
      chk("rstwr_readback", d_rd, 16'h2222);

      // Video starvation limit: DAP read waits for exactly 8 video grants
      @(negedge clk);
      a0 = vid_tot;
      vid_addr = 18'h00100; vid_rq = 1'b1;
      addr = 24'h0000AA; r_rq = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (rq_ack) got = 1'b1;
      end
      r_rq = 1'b0;
      chk("starve_ack_seen", got, 1);
      chk("starve_vid_acks", vid_tot - a0, 8);
      chk("starve_d_rd", d_rd, 16'hCAFE);
      chk("starve_vid_cnt_clear", dut.vid_cnt, 0);
      chk("starve_vid_data", vid_data, 16'h7777);
      vid_rq = 1'b0;
      repeat (8) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
